// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI register slave.
//                FSM state encoding, command-bit values and the bit-counter
//                width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } spi_state_t;

    localparam logic SPI_CMD_READ  = 1'b1;
    localparam logic SPI_CMD_WRITE = 1'b0;

    // Counter must hold values up to max(ADDR_W, DATA_W).
    function automatic int cnt_width(input int aw, input int dw);
        return $clog2(((aw > dw) ? aw : dw) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_reg_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_slave_if
//  Description : Register-file port between the SPI slave and the register
//                file.
//                master : SPI side (issues write strobes and read requests)
//                slave  : register-file side (answers reads)
//  Signals     : wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_valid, rd_data
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_reg_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_req, rd_addr,
        input  rd_valid, rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_req, rd_addr,
        output rd_valid, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pin_sync
//  Description : Synchronises sclk/cs_n/mosi into the clk domain and decodes
//                the synchronised sclk into sample and shift edge strobes
//                according to CPOL/CPHA.
//  Ports       : clk, reset              - system clock, async active-high reset
//                sclk, cs_n, mosi        - raw SPI pins
//                sclk_sample, sclk_shift - one-clk edge strobes
//                cs_n_s, mosi_s          - synchronised pins
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic sclk,
    input  wire logic cs_n,
    input  wire logic mosi,
    output logic      sclk_sample,
    output logic      sclk_shift,
    output logic      cs_n_s,
    output logic      mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_d;
    logic                   sclk_s;
    logic                   sclk_rise;
    logic                   sclk_fall;

    // Reset to the idle pin levels so no spurious edge/select is seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q <= {SYNC_STAGES{CPOL}};
            cs_q   <= '1;
            mosi_q <= '0;
            sclk_d <= CPOL;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_d <= sclk_s;
        end
    end

    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign cs_n_s    = cs_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling.
    generate
        if (CPOL == CPHA) begin : g_sample_rise
            assign sclk_sample = sclk_rise;
            assign sclk_shift  = sclk_fall;
        end else begin : g_sample_fall
            assign sclk_sample = sclk_fall;
            assign sclk_shift  = sclk_rise;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_slave
//  Description : SPI slave bridging an external master to a register file.
//                Frame = cmd bit (1=read) + ADDR_W address + DATA_W data,
//                MSB first, any CPOL/CPHA mode.
//  Ports       : clk, reset         - system clock, async active-high reset
//                sclk, cs_n, mosi   - SPI inputs (asynchronous)
//                miso, miso_oe      - SPI output and its pad enable
//                rd_late            - read data missed the first MISO edge
//                frame_err          - cs_n rose before the frame completed
//                busy               - frame in progress
//                bus                - register-file port (master side)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_slave
    import spi_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        sclk,
    input  wire logic        cs_n,
    input  wire logic        mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic             rd_late,
    output logic             frame_err,
    output logic             busy,
    spi_reg_slave_if.master  bus
);

    localparam int                CNT_W     = cnt_width(ADDR_W, DATA_W);
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);

    logic sclk_sample, sclk_shift, cs_n_s, mosi_s;

    spi_pin_sync #(
        .CPOL        (CPOL),
        .CPHA        (CPHA),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk         (clk),
        .reset       (reset),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .sclk_sample (sclk_sample),
        .sclk_shift  (sclk_shift),
        .cs_n_s      (cs_n_s),
        .mosi_s      (mosi_s)
    );

    spi_state_t        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic              cmd;
    logic [ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0] data_sh;
    logic [DATA_W-1:0] tx_sh;
    logic              tx_loaded;
    logic              rd_wait;
    logic              late;
    logic              cs_n_d;
    logic              frame_abort;

    logic              cs_fall, cs_rise, sample_ok, shift_ok;
    logic              addr_last, data_last;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;

    assign cs_fall   = cs_n_d & ~cs_n_s;
    assign cs_rise   = ~cs_n_d & cs_n_s;
    // A cs_n rise outranks any sclk edge seen in the same clk.
    assign sample_ok = sclk_sample & ~cs_rise;
    assign shift_ok  = sclk_shift & ~cs_rise & (state == DATA) & (cmd == SPI_CMD_READ);
    assign addr_next = (addr_sh << 1) | ADDR_W'(mosi_s);
    assign data_next = (data_sh << 1) | DATA_W'(mosi_s);
    assign addr_last = (state == ADDR) & sample_ok & (cnt == ADDR_LAST);
    assign data_last = (state == DATA) & sample_ok & (cnt == DATA_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_abort = 1'b0;
        busy        = (state != IDLE);
        miso_oe     = (state != IDLE);
        if (state == IDLE) begin
            if (cs_fall) state_next = CMD;
        end else if (cs_rise) begin
            state_next  = IDLE;
            frame_abort = (state != DONE);
        end else if (sample_ok) begin
            case (state)
                CMD:     state_next = ADDR;
                ADDR:    if (addr_last) state_next = DATA;
                DATA:    if (data_last) state_next = DONE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n_d      <= 1'b1;
            cnt         <= '0;
            cmd         <= 1'b0;
            addr_sh     <= '0;
            data_sh     <= '0;
            tx_sh       <= '0;
            tx_loaded   <= 1'b0;
            rd_wait     <= 1'b0;
            late        <= 1'b0;
            miso        <= 1'b0;
            rd_late     <= 1'b0;
            frame_err   <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.rd_req  <= 1'b0;
            bus.rd_addr <= '0;
        end else begin
            cs_n_d     <= cs_n_s;
            bus.wr_en  <= 1'b0;
            bus.rd_req <= 1'b0;
            rd_late    <= 1'b0;
            frame_err  <= frame_abort;

            if (state_next != state)
                cnt <= '0;
            else if (sample_ok && (state == ADDR || state == DATA))
                cnt <= cnt + CNT_W'(1);

            if (state == IDLE && cs_fall) begin
                cmd       <= 1'b0;
                addr_sh   <= '0;
                data_sh   <= '0;
                tx_sh     <= '0;
                tx_loaded <= 1'b0;
                rd_wait   <= 1'b0;
                late      <= 1'b0;
                miso      <= 1'b0;
            end

            if (cs_rise) begin
                miso    <= 1'b0;
                rd_wait <= 1'b0;
            end

            if (sample_ok) begin
                case (state)
                    CMD: cmd <= mosi_s;
                    ADDR: begin
                        addr_sh <= addr_next;
                        if (addr_last && cmd == SPI_CMD_READ) begin
                            bus.rd_req  <= 1'b1;
                            bus.rd_addr <= addr_next;
                            rd_wait     <= 1'b1;
                        end
                    end
                    DATA: begin
                        data_sh <= data_next;
                        if (data_last) begin
                            miso <= 1'b0;
                            if (cmd == SPI_CMD_WRITE) begin
                                bus.wr_en   <= 1'b1;
                                bus.wr_addr <= addr_sh;
                                bus.wr_data <= data_next;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            // Data arriving on the same clk as the first shift edge counts as late.
            if (rd_wait && bus.rd_valid && !shift_ok) begin
                tx_sh     <= bus.rd_data;
                tx_loaded <= 1'b1;
                rd_wait   <= 1'b0;
            end

            if (shift_ok) begin
                if (tx_loaded) begin
                    miso  <= tx_sh[DATA_W-1];
                    tx_sh <= tx_sh << 1;
                end else begin
                    // Missed the first edge: stay silent for the rest of the frame.
                    miso    <= 1'b0;
                    rd_wait <= 1'b0;
                    if (!late) begin
                        late    <= 1'b1;
                        rd_late <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_reg_slave
//  Description : Scoreboard bench for spi_reg_slave. Five instances:
//                0..3 = modes 0..3 with 4-bit address / 8-bit data,
//                4    = mode 2 with 7-bit address / 16-bit data.
//                sclk and mosi are shared; each instance has its own cs_n.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_slave;

    localparam int HALF  = 8;
    localparam int K_RD   = 0;
    localparam int K_LATE = 1;
    localparam int K_WR   = 2;
    localparam int K_FERR = 3;
    localparam int K_MISO = 4;

    logic clk = 1'b0;
    logic reset;
    logic sclk;
    logic mosi;
    logic [4:0] cs_n_v;

    logic [4:0]  wr_en_v, rd_req_v, rd_late_v, ferr_v, busy_v, miso_v, oe_v;
    logic [15:0] wr_addr_a [5];
    logic [15:0] rd_addr_a [5];
    logic [31:0] wr_data_a [5];
    int          rd_delay  [5];

    int n_checks = 0;
    int n_pass   = 0;
    int rx_seq   = 0;
    int rx_word  = 0;
    int rx_inst  = 0;

    typedef struct {
        int kind;
        int inst;
        int a;
        int d;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 5; i++) begin : g_dut
        localparam int AW = (i == 4) ? 7 : 4;
        localparam int DW = (i == 4) ? 16 : 8;
        localparam bit PL = (i == 4) ? 1'b1 : ((i & 2) != 0);
        localparam bit PH = (i == 4) ? 1'b0 : ((i & 1) != 0);

        spi_reg_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        logic        miso, miso_oe, rd_late, frame_err, busy;
        logic        rv;
        logic [31:0] rdd;
        logic [31:0] mem [128];

        spi_reg_slave #(
            .ADDR_W(AW), .DATA_W(DW), .CPOL(PL), .CPHA(PH), .SYNC_STAGES(2)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .sclk      (sclk),
            .cs_n      (cs_n_v[i]),
            .mosi      (mosi),
            .miso      (miso),
            .miso_oe   (miso_oe),
            .rd_late   (rd_late),
            .frame_err (frame_err),
            .busy      (busy),
            .bus       (bus)
        );

        assign bus.rd_valid = rv;
        assign bus.rd_data  = rdd[DW-1:0];
        assign wr_en_v[i]   = bus.wr_en;
        assign rd_req_v[i]  = bus.rd_req;
        assign rd_late_v[i] = rd_late;
        assign ferr_v[i]    = frame_err;
        assign busy_v[i]    = busy;
        assign miso_v[i]    = miso;
        assign oe_v[i]      = miso_oe;
        assign wr_addr_a[i] = 16'(bus.wr_addr);
        assign rd_addr_a[i] = 16'(bus.rd_addr);
        assign wr_data_a[i] = 32'(bus.wr_data);

        // Register-file model: writes land in mem, reads answer after rd_delay clks.
        initial begin
            rv  = 1'b0;
            rdd = '0;
            for (int j = 0; j < 128; j++) mem[j] = '0;
            mem[9] = 32'h3C;
            forever begin
                @(negedge clk);
                if (bus.wr_en) mem[7'(bus.wr_addr)] = 32'(bus.wr_data);
                if (bus.rd_req) begin
                    repeat (rd_delay[i] - 1) @(negedge clk);
                    rdd = mem[7'(bus.rd_addr)];
                    rv  = 1'b1;
                    @(negedge clk);
                    rv  = 1'b0;
                    rdd = '0;
                end
            end
        end
    end

    function automatic int aw_of(input int k); return (k == 4) ? 7 : 4; endfunction
    function automatic int dw_of(input int k); return (k == 4) ? 16 : 8; endfunction
    function automatic bit pl_of(input int k); return (k == 4) ? 1'b1 : ((k & 2) != 0); endfunction
    function automatic bit ph_of(input int k); return (k == 4) ? 1'b0 : ((k & 1) != 0); endfunction

    function automatic string kname(input int k);
        case (k)
            K_RD:    return "rd_req";
            K_LATE:  return "rd_late";
            K_WR:    return "wr_en";
            K_FERR:  return "frame_err";
            default: return "miso_word";
        endcase
    endfunction

    task automatic push(input int kind, input int inst, input int a, input int d);
        exp_t e;
        e.kind = kind; e.inst = inst; e.a = a; e.d = d;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input int inst, input int a, input int d);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s inst%0d: unexpected output a=%h d=%h, required nothing",
                     kname(kind), inst, a, d);
            return;
        end
        e = sb.pop_front();
        if (e.kind != kind || e.inst != inst || e.a != a || e.d != d)
            $display("FAIL %s inst%0d: got a=%h d=%h, required %s inst%0d a=%h d=%h",
                     kname(kind), inst, a, d, kname(e.kind), e.inst, e.a, e.d);
        else
            n_pass++;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) $display("FAIL %s: got %h, required %h", nm, act, exp);
        else            n_pass++;
    endtask

    // Drives one frame; cut > 0 stops after that many bits. The data bits
    // seen on miso at each sample edge are published to the monitor.
    task automatic frame(input int k, input bit c, input int addr, input int data, input int cut);
        int aw, dw, nb, rx;
        bit pl, ph, bv;
        aw = aw_of(k); dw = dw_of(k); pl = pl_of(k); ph = ph_of(k);
        nb = (cut > 0) ? cut : 1 + aw + dw;
        rx = 0;
        sclk = pl;
        repeat (6) @(negedge clk);
        cs_n_v[k] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (b == 0)       bv = c;
            else if (b <= aw) bv = ((addr >> (aw - b)) & 1) != 0;
            else              bv = ((data >> (aw + dw - b)) & 1) != 0;
            if (!ph) begin
                mosi = bv;
                repeat (HALF) @(negedge clk);
                if (b > aw) rx = (rx << 1) | int'(miso_v[k]);
                sclk = ~pl;
                repeat (HALF) @(negedge clk);
                sclk = pl;
            end else begin
                repeat (HALF) @(negedge clk);
                sclk = ~pl;
                mosi = bv;
                repeat (HALF) @(negedge clk);
                if (b > aw) rx = (rx << 1) | int'(miso_v[k]);
                sclk = pl;
            end
        end
        repeat (HALF) @(negedge clk);
        cs_n_v[k] = 1'b1;
        repeat (12) @(negedge clk);
        rx_word = rx;
        rx_inst = k;
        rx_seq++;
    endtask

    // Monitor: every DUT output event pops and compares the next expectation.
    initial begin
        int seen;
        seen = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                if (rd_req_v[i])  observe(K_RD, i, int'(rd_addr_a[i]), 0);
                if (rd_late_v[i]) observe(K_LATE, i, 0, 0);
                if (wr_en_v[i])   observe(K_WR, i, int'(wr_addr_a[i]), int'(wr_data_a[i]));
                if (ferr_v[i])    observe(K_FERR, i, 0, 0);
            end
            if (rx_seq != seen) begin
                seen = rx_seq;
                observe(K_MISO, rx_inst, rx_word, 0);
            end
        end
    end

    initial begin
        #400us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        sclk   = 1'b0;
        mosi   = 1'b0;
        cs_n_v = '1;
        for (int i = 0; i < 5; i++) rd_delay[i] = 1;
        repeat (4) @(negedge clk);
        #1;
        check("reset_busy",    int'(busy_v), 0);
        check("reset_miso_oe", int'(oe_v), 0);
        check("reset_miso",    int'(miso_v), 0);
        check("reset_strobes", int'(wr_en_v | rd_req_v | rd_late_v | ferr_v), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0 write
        push(K_WR, 0, 'h5, 'hA3); push(K_MISO, 0, 0, 0);
        frame(0, 1'b0, 'h5, 'hA3, 0);

        // Mode 3 read of preset 0x3C
        push(K_RD, 3, 'h9, 0); push(K_MISO, 3, 'h3C, 0);
        frame(3, 1'b1, 'h9, 0, 0);

        // Modes 1 and 2 write then read back
        for (int k = 1; k <= 2; k++) begin
            push(K_WR, k, 'h2, 'hFF); push(K_MISO, k, 0, 0);
            frame(k, 1'b0, 'h2, 'hFF, 0);
            push(K_RD, k, 'h2, 0); push(K_MISO, k, 'hFF, 0);
            frame(k, 1'b1, 'h2, 0, 0);
        end

        // Wide instance
        push(K_WR, 4, 'h55, 'hBEEF); push(K_MISO, 4, 0, 0);
        frame(4, 1'b0, 'h55, 'hBEEF, 0);
        push(K_RD, 4, 'h55, 0); push(K_MISO, 4, 'hBEEF, 0);
        frame(4, 1'b1, 'h55, 0, 0);

        // Truncated frame, then normal traffic
        push(K_FERR, 0, 0, 0); push(K_MISO, 0, 0, 0);
        frame(0, 1'b0, 'h3, 'h5A, 6);
        push(K_WR, 0, 'h3, 'h5A); push(K_MISO, 0, 0, 0);
        frame(0, 1'b0, 'h3, 'h5A, 0);
        push(K_RD, 0, 'h3, 0); push(K_MISO, 0, 'h5A, 0);
        frame(0, 1'b1, 'h3, 0, 0);

        // Read data arrives too late
        rd_delay[0] = 20;
        push(K_RD, 0, 'h9, 0); push(K_LATE, 0, 0, 0); push(K_MISO, 0, 0, 0);
        frame(0, 1'b1, 'h9, 0, 0);
        rd_delay[0] = 1;

        // Reset during the data phase of a write
        push(K_MISO, 0, 0, 0);
        fork
            frame(0, 1'b0, 'hC, 'h77, 0);
            begin
                for (int t = 0; t < 100 && !busy_v[0]; t++) @(negedge clk);
                repeat (120) @(negedge clk);
                check("busy_mid_frame", int'(busy_v[0]), 1);
                check("oe_mid_frame",   int'(oe_v[0]), 1);
                reset = 1'b1;
                #1;
                check("rst_busy",    int'(busy_v[0]), 0);
                check("rst_miso_oe", int'(oe_v[0]), 0);
                check("rst_wr_addr", int'(wr_addr_a[0]), 0);
                check("rst_wr_data", int'(wr_data_a[0]), 0);
                check("rst_rd_addr", int'(rd_addr_a[0]), 0);
            end
        join
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        push(K_WR, 0, 'hC, 'h96); push(K_MISO, 0, 0, 0);
        frame(0, 1'b0, 'hC, 'h96, 0);
        push(K_RD, 0, 'hC, 0); push(K_MISO, 0, 'h96, 0);
        frame(0, 1'b1, 'hC, 0, 0);

        repeat (20) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
